// File: rtl/tftp_pkg.sv
// Shared TFTP definitions: opcode values, parser state encoding and the well-known port.
package tftp_pkg;

    localparam logic [15:0] OP_RRQ   = 16'h0001;
    localparam logic [15:0] OP_WRQ   = 16'h0002;
    localparam logic [15:0] OP_DATA  = 16'h0003;
    localparam logic [15:0] OP_ACK   = 16'h0004;
    localparam logic [15:0] OP_ERROR = 16'h0005;
    localparam logic [15:0] OP_OACK  = 16'h0006;

    localparam logic [15:0] TFTP_PORT = 16'd69;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        OP_HI,
        OP_LO,
        BLK_HI,
        BLK_LO,
        HOLD
    } parse_state_e;

    // One-hot opcode flag vector, bit0 = RRQ ... bit5 = OACK; zero for anything illegal.
    function automatic logic [5:0] op_onehot(input logic [15:0] op);
        logic [5:0] hot;
        hot = 6'b000000;
        case (op)
            OP_RRQ:   hot = 6'b000001;
            OP_WRQ:   hot = 6'b000010;
            OP_DATA:  hot = 6'b000100;
            OP_ACK:   hot = 6'b001000;
            OP_ERROR: hot = 6'b010000;
            OP_OACK:  hot = 6'b100000;
            default:  hot = 6'b000000;
        endcase
        return hot;
    endfunction

endpackage

// File: rtl/tftp_be16_capture.sv
// Big-endian 16-bit field capture over two byte beats; clear has priority over both loads.
module tftp_be16_capture (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        load_hi_i,
    input  logic        load_lo_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] value_o
);

    logic [15:0] value_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= 16'h0000;
        end else if (clear_i) begin
            value_q <= 16'h0000;
        end else if (load_hi_i) begin
            value_q[15:8] <= byte_i;
        end else if (load_lo_i) begin
            value_q[7:0] <= byte_i;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/tftp_opcode_parser.sv
// Receive-path TFTP opcode parser: skips a header, decodes the opcode into sticky
// one-hot flags and captures the block number / error code that follows.
//
//  state  | meaning
//  IDLE   | no frame seen since reset, beats ignored
//  SKIP   | dropping header bytes ahead of the opcode
//  OP_HI  | next beat is the opcode high byte
//  OP_LO  | next beat is the opcode low byte, decode on it
//  BLK_HI | next beat is blk_num[15:8]
//  BLK_LO | next beat is blk_num[7:0], parse completes
//  HOLD   | parse complete, wait for the next sof
module tftp_opcode_parser
    import tftp_pkg::*;
#(
    parameter int         HDR_OFFSET = 0,
    parameter logic [5:0] OP_MASK    = 6'b111111,
    parameter int         DATA_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sof,
    input  logic [DATA_W-1:0] eth_data,
    output logic              req,
    output logic              wrq,
    output logic              data,
    output logic              ack,
    output logic              err,
    output logic              oack,
    output logic              bad_op,
    output logic [15:0]       blk_num,
    output logic              blk_valid,
    output logic              done
);

    if (DATA_W != 8) begin : g_bad_data_w
        $error("tftp_opcode_parser: DATA_W must be 8");
    end
    if (HDR_OFFSET < 0 || HDR_OFFSET > 63) begin : g_bad_offset
        $error("tftp_opcode_parser: HDR_OFFSET must be 0..63");
    end

    localparam logic [5:0] SKIP_LOAD = (HDR_OFFSET > 1) ? 6'(HDR_OFFSET - 1) : 6'd0;

    parse_state_e state_q;
    logic [5:0]   skip_q;
    logic [7:0]   op_hi_q;
    logic [5:0]   flags_q;
    logic         bad_q;
    logic         valid_q;
    logic         done_q;

    logic [15:0]  opcode;
    logic [5:0]   hit;
    logic         has_blk;

    assign opcode  = {op_hi_q, eth_data};
    assign hit     = op_onehot(opcode) & OP_MASK;
    assign has_blk = (opcode == OP_DATA) || (opcode == OP_ACK) || (opcode == OP_ERROR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            skip_q  <= 6'd0;
            op_hi_q <= 8'h00;
            flags_q <= 6'b000000;
            bad_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (en && sof) begin
                flags_q <= 6'b000000;
                bad_q   <= 1'b0;
                valid_q <= 1'b0;
                skip_q  <= SKIP_LOAD;
                if (HDR_OFFSET == 0) begin
                    op_hi_q <= eth_data;
                    state_q <= OP_LO;
                end else if (HDR_OFFSET == 1) begin
                    state_q <= OP_HI;
                end else begin
                    state_q <= SKIP;
                end
            end else if (en) begin
                case (state_q)
                    SKIP: begin
                        skip_q <= skip_q - 6'd1;
                        if (skip_q == 6'd1) begin
                            state_q <= OP_HI;
                        end
                    end
                    OP_HI: begin
                        op_hi_q <= eth_data;
                        state_q <= OP_LO;
                    end
                    OP_LO: begin
                        // Block-carrying opcodes defer done until the field is captured.
                        if (hit != 6'b000000) begin
                            flags_q <= hit;
                            if (has_blk) begin
                                state_q <= BLK_HI;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= HOLD;
                            end
                        end else begin
                            bad_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= HOLD;
                        end
                    end
                    BLK_HI: state_q <= BLK_LO;
                    BLK_LO: begin
                        valid_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= HOLD;
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    tftp_be16_capture u_blk_cap (
        .clk       (clk),
        .rst       (reset),
        .clear_i   (en && sof),
        .load_hi_i (en && !sof && (state_q == BLK_HI)),
        .load_lo_i (en && !sof && (state_q == BLK_LO)),
        .byte_i    (eth_data),
        .value_o   (blk_num)
    );

    assign req       = flags_q[0];
    assign wrq       = flags_q[1];
    assign data      = flags_q[2];
    assign ack       = flags_q[3];
    assign err       = flags_q[4];
    assign oack      = flags_q[5];
    assign bad_op    = bad_q;
    assign blk_valid = valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tftp_opcode_parser.sv
// Bench for tftp_opcode_parser: three parameterisations driven by one byte stream,
// each checked against a byte-position reference model, plus directed vector tables.
module tb_tftp_opcode_parser;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       sof;
    logic [7:0] eth_data;

    logic [2:0]       req_w, wrq_w, data_w, ack_w, err_w, oack_w, bad_w, bv_w, dn_w;
    logic [2:0][15:0] bn_w;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tftp_opcode_parser #(.HDR_OFFSET(0), .OP_MASK(6'b111111), .DATA_W(8)) u0 (
        .clk(clk), .reset(reset), .en(en), .sof(sof), .eth_data(eth_data),
        .req(req_w[0]), .wrq(wrq_w[0]), .data(data_w[0]), .ack(ack_w[0]), .err(err_w[0]),
        .oack(oack_w[0]), .bad_op(bad_w[0]), .blk_num(bn_w[0]), .blk_valid(bv_w[0]), .done(dn_w[0]));

    tftp_opcode_parser #(.HDR_OFFSET(0), .OP_MASK(6'b110111), .DATA_W(8)) u1 (
        .clk(clk), .reset(reset), .en(en), .sof(sof), .eth_data(eth_data),
        .req(req_w[1]), .wrq(wrq_w[1]), .data(data_w[1]), .ack(ack_w[1]), .err(err_w[1]),
        .oack(oack_w[1]), .bad_op(bad_w[1]), .blk_num(bn_w[1]), .blk_valid(bv_w[1]), .done(dn_w[1]));

    tftp_opcode_parser #(.HDR_OFFSET(4), .OP_MASK(6'b111111), .DATA_W(8)) u2 (
        .clk(clk), .reset(reset), .en(en), .sof(sof), .eth_data(eth_data),
        .req(req_w[2]), .wrq(wrq_w[2]), .data(data_w[2]), .ack(ack_w[2]), .err(err_w[2]),
        .oack(oack_w[2]), .bad_op(bad_w[2]), .blk_num(bn_w[2]), .blk_valid(bv_w[2]), .done(dn_w[2]));

    // Reference model: tracks payload byte index since the last sof.
    int         cfg_off  [3] = '{0, 0, 4};
    logic [5:0] cfg_mask [3] = '{6'b111111, 6'b110111, 6'b111111};
    int         pos      [3];
    logic [7:0] hi_b     [3];
    bit         blk_e    [3];
    logic [6:0] m_flags  [3];
    logic [15:0] m_bn    [3];
    bit         m_bv     [3];
    bit         m_dn     [3];

    function automatic logic [6:0] act_flags(input int k);
        return {bad_w[k], oack_w[k], err_w[k], ack_w[k], data_w[k], wrq_w[k], req_w[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            pos[k] = -1; hi_b[k] = 8'h00; blk_e[k] = 1'b0;
            m_flags[k] = 7'h00; m_bn[k] = 16'h0000; m_bv[k] = 1'b0; m_dn[k] = 1'b0;
        end
    endtask

    task automatic model_beat(input int k, input bit s, input logic [7:0] d);
        int rel;
        int op;
        m_dn[k] = 1'b0;
        if (s) begin
            pos[k] = 0; blk_e[k] = 1'b0;
            m_flags[k] = 7'h00; m_bn[k] = 16'h0000; m_bv[k] = 1'b0;
        end else if (pos[k] >= 0) begin
            if (pos[k] < 1000) pos[k] = pos[k] + 1;
        end else begin
            return;
        end
        rel = pos[k] - cfg_off[k];
        if (rel == 0) hi_b[k] = d;
        if (rel == 1) begin
            op = int'(hi_b[k]) * 256 + int'(d);
            if (op >= 1 && op <= 6 && cfg_mask[k][op-1]) begin
                m_flags[k][op-1] = 1'b1;
                if (op >= 3 && op <= 5) blk_e[k] = 1'b1;
                else m_dn[k] = 1'b1;
            end else begin
                m_flags[k][6] = 1'b1;
                m_dn[k] = 1'b1;
            end
        end
        if (rel == 2 && blk_e[k]) m_bn[k][15:8] = d;
        if (rel == 3 && blk_e[k]) begin
            m_bn[k][7:0] = d;
            m_bv[k] = 1'b1;
            m_dn[k] = 1'b1;
        end
    endtask

    task automatic check_all(input string name);
        logic [24:0] act, exp;
        for (int k = 0; k < 3; k++) begin
            act = {act_flags(k), bn_w[k], bv_w[k], dn_w[k]};
            exp = {m_flags[k], m_bn[k], m_bv[k], m_dn[k]};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL %s dut%0d got flags=%b blk=%h v=%b d=%b want flags=%b blk=%h v=%b d=%b",
                         name, k, act[24:18], act[17:2], act[1], act[0],
                         exp[24:18], exp[17:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the following negedge.
    task automatic step(input bit e, input bit s, input logic [7:0] d, input string name);
        en = e; sof = s; eth_data = d;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (e) model_beat(k, s, d);
            else m_dn[k] = 1'b0;
        end
        @(negedge clk);
        check_all(name);
    endtask

    typedef struct {
        bit          e;
        bit          s;
        logic [7:0]  d;
        logic [6:0]  f;
        logic [15:0] bn;
        bit          bv;
        bit          dn;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 8'h00, 7'h00, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h01, 7'h01, 16'h0000, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 8'h55, 7'h01, 16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 8'h00, 7'h00, 16'h0000, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h04, 7'h08, 16'h0000, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'h12, 7'h08, 16'h0000, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h12, 7'h08, 16'h0000, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h12, 7'h08, 16'h0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'h12, 7'h08, 16'h1200, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'h34, 7'h08, 16'h1234, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 8'h99, 7'h08, 16'h1234, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 8'h0F, 7'h00, 16'h0000, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'h09, 7'h40, 16'h0000, 1'b0, 1'b1};

        reset = 1'b1; en = 1'b0; sof = 1'b0; eth_data = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset_state");
        reset = 1'b0;
        step(1'b1, 1'b0, 8'h00, "idle_ignore");
        step(1'b1, 1'b0, 8'h01, "idle_ignore");

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].e, tbl[i].s, tbl[i].d, "table_model");
            check_val($sformatf("table_%0d", i),
                      {7'd0, act_flags(0), bn_w[0], bv_w[0], dn_w[0]},
                      {7'd0, tbl[i].f, tbl[i].bn, tbl[i].bv, tbl[i].dn});
        end

        // ACK masked off on u1
        step(1'b1, 1'b1, 8'h00, "mask");
        step(1'b1, 1'b0, 8'h04, "mask");
        check_val("mask_bad_op", {25'd0, act_flags(1)}, 32'h40);

        // Header offset 4 on u2, ERROR code 2, then trailing bytes
        step(1'b1, 1'b1, 8'hAA, "hdr4");
        step(1'b1, 1'b0, 8'hBB, "hdr4");
        step(1'b1, 1'b0, 8'hCC, "hdr4");
        step(1'b1, 1'b0, 8'hDD, "hdr4");
        step(1'b1, 1'b0, 8'h00, "hdr4");
        step(1'b1, 1'b0, 8'h05, "hdr4");
        step(1'b1, 1'b0, 8'h00, "hdr4");
        step(1'b1, 1'b0, 8'h02, "hdr4");
        check_val("hdr4_err", {7'd0, act_flags(2), bn_w[2], bv_w[2], dn_w[2]},
                  {7'd0, 7'h10, 16'h0002, 1'b1, 1'b1});
        step(1'b1, 1'b0, 8'h00, "hdr4_trail");
        step(1'b1, 1'b0, 8'h07, "hdr4_trail");
        check_val("hdr4_hold", {7'd0, act_flags(2), bn_w[2], bv_w[2], dn_w[2]},
                  {7'd0, 7'h10, 16'h0002, 1'b1, 1'b0});

        // Restart mid DATA block, then WRQ
        step(1'b1, 1'b1, 8'h00, "restart");
        step(1'b1, 1'b0, 8'h03, "restart");
        step(1'b1, 1'b0, 8'hAB, "restart");
        step(1'b1, 1'b1, 8'h00, "restart");
        step(1'b1, 1'b0, 8'h02, "restart");
        check_val("restart_wrq", {7'd0, act_flags(0), bn_w[0], bv_w[0], dn_w[0]},
                  {7'd0, 7'h02, 16'h0000, 1'b0, 1'b1});

        // sof on the beat that would complete the block: no done
        step(1'b1, 1'b1, 8'h00, "sof_wins");
        step(1'b1, 1'b0, 8'h04, "sof_wins");
        step(1'b1, 1'b0, 8'h12, "sof_wins");
        step(1'b1, 1'b1, 8'h00, "sof_wins");
        check_val("sof_wins_no_done", {31'd0, dn_w[0]}, 32'd0);
        step(1'b1, 1'b0, 8'h01, "sof_wins");

        // Async reset while u0 sits in BLK_HI
        step(1'b1, 1'b1, 8'h00, "rst_mid");
        step(1'b1, 1'b0, 8'h03, "rst_mid");
        en = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b1, 8'h00, "after_rst");
        step(1'b1, 1'b0, 8'h06, "after_rst");
        check_val("after_rst_oack", {25'd0, act_flags(0)}, 32'h20);

        // Randomized stream against the model
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, d, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
